data_mem_flat: RTL and testbench

Single-port, byte-addressed data memory serving the core's load/store unit and the bench's preload path. Requests and responses cross the boundary as flattened `mem_in_s`/`mem_out_s` buses, and the address arrives on a separate 32-bit port. Each accepted request produces a registered response one cycle later under a valid/yumi handshake. Addresses outside the array, such as the 0xDEAD_DEAD and 0x600D_BEEF pass/fail markers, are acknowledged but leave the array untouched.

---
 rtl/definitions.sv | 29 ++
 rtl/data_mem_array.sv | 41 ++++
 rtl/data_mem_flat.sv | 96 +++++++++
 tb/tb_data_mem_flat.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/definitions.sv
// Shared memory-port types and word-width constants used by the data memory and the core.
package definitions;

  localparam int unsigned WordWidth = 32;
  localparam int unsigned ByteLanes = WordWidth / 8;

  typedef struct packed {
    logic                 valid;
    logic                 wen;
    logic                 byte_not_word;
    logic [WordWidth-1:0] write_data;
    logic                 yumi;
  } mem_in_s;

  typedef struct packed {
    logic                 valid;
    logic                 yumi;
    logic [WordWidth-1:0] read_data;
  } mem_out_s;

  // One-hot byte enable for a little-endian lane.
  function automatic logic [ByteLanes-1:0] lane_mask(input logic [1:0] lane);
    logic [ByteLanes-1:0] mask;
    mask       = '0;
    mask[lane] = 1'b1;
    return mask;
  endfunction

endpackage

// File: rtl/data_mem_array.sv
// Byte-enabled words_p x 32 RAM: synchronous write, registered read port.
module data_mem_array
  import definitions::*;
#(
  parameter  int unsigned words_p  = 1024,
  localparam int unsigned AddrBits = $clog2(words_p)
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_wen,
  input  logic [ByteLanes-1:0] i_be,
  input  logic [AddrBits-1:0]  i_idx,
  input  logic [WordWidth-1:0] i_wdata,
  input  logic                 i_ren,
  input  logic                 i_rzero,
  output logic [WordWidth-1:0] o_rdata
);

  logic [WordWidth-1:0] r_mem [words_p];
  logic [WordWidth-1:0] r_rdata;

  // Storage is deliberately not reset so contents survive a reset pulse.
  always_ff @(posedge i_clk) begin
    if (i_wen) begin
      for (int b = 0; b < int'(ByteLanes); b++) begin
        if (i_be[b]) r_mem[i_idx][b*8 +: 8] <= i_wdata[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rdata <= '0;
    end else if (i_ren) begin
      r_rdata <= i_rzero ? '0 : r_mem[i_idx];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/data_mem_flat.sv
// Byte-addressed data memory behind flattened mem_in_s/mem_out_s buses with a valid/yumi handshake.
module data_mem_flat
  import definitions::*;
#(
  parameter int unsigned words_p = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [35:0] port_flat_i,
  input  logic [31:0] addr,
  output logic [33:0] port_flat_o
);

  localparam int unsigned AddrBits = $clog2(words_p);

  mem_in_s                 w_in;
  mem_out_s                w_out;
  logic                    r_pending;
  logic                    r_byte_rd;
  logic [1:0]              r_lane;
  logic                    w_accept;
  logic                    w_in_range;
  logic                    w_wen;
  logic                    w_ren;
  logic [ByteLanes-1:0]    w_be;
  logic [WordWidth-1:0]    w_wdata;
  logic [WordWidth-1:0]    w_rdata;
  logic [WordWidth-1:0]    w_read_data;
  logic [AddrBits-1:0]     w_idx;

  assign w_in        = port_flat_i;
  assign port_flat_o = w_out;

  assign w_idx      = addr[AddrBits+1:2];
  assign w_in_range = (addr >> (AddrBits + 2)) == 32'd0;

  always_comb begin
    w_accept = w_in.valid & (~r_pending | w_in.yumi);
    w_wen    = w_accept & w_in.wen & w_in_range;
    w_ren    = w_accept & ~w_in.wen;
    if (w_in.byte_not_word) begin
      w_be    = lane_mask(addr[1:0]);
      w_wdata = {ByteLanes{w_in.write_data[7:0]}};
    end else begin
      w_be    = '1;
      w_wdata = w_in.write_data;
    end
  end

  data_mem_array #(
    .words_p (words_p)
  ) u_array (
    .i_clk   (clk),
    .i_rst   (reset),
    .i_wen   (w_wen),
    .i_be    (w_be),
    .i_idx   (w_idx),
    .i_wdata (w_wdata),
    .i_ren   (w_ren),
    .i_rzero (~w_in_range),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pending <= 1'b0;
    end else if (w_accept) begin
      r_pending <= 1'b1;
    end else if (w_in.yumi) begin
      r_pending <= 1'b0;
    end
  end

  // Lane selection is captured with the read so the response holds even if the request changes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_byte_rd <= 1'b0;
      r_lane    <= 2'd0;
    end else if (w_ren) begin
      r_byte_rd <= w_in.byte_not_word;
      r_lane    <= addr[1:0];
    end
  end

  always_comb begin
    w_read_data = w_rdata;
    if (r_byte_rd) w_read_data = {24'd0, w_rdata[{r_lane, 3'b000} +: 8]};
  end

  always_comb begin
    w_out.valid     = r_pending;
    w_out.yumi      = w_accept;
    w_out.read_data = w_read_data;
  end

endmodule

// File: tb/tb_data_mem_flat.sv
// Scoreboard bench for data_mem_flat: stimulus pushes expected responses, a monitor pops them.
module tb_data_mem_flat;

  logic        clk = 1'b0;
  logic        reset;
  logic [35:0] port_flat_i;
  logic [31:0] addr;
  logic [33:0] port_flat_o;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  logic [31:0] exp_q[$];
  logic        m_pend;
  logic [31:0] m_rd;

  always #5 clk = ~clk;

  data_mem_flat #(
    .words_p (1024)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .port_flat_i (port_flat_i),
    .addr        (addr),
    .port_flat_o (port_flat_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // A response is consumed at the next rising edge when valid and yumi are both high.
  always @(negedge clk) begin
    if (reset === 1'b0 && port_flat_o[33] === 1'b1 && port_flat_i[0] === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL response: got %h expected no response (t=%0t)", port_flat_o[31:0], $time);
      end else begin
        check("response", port_flat_o[31:0], exp_q.pop_front());
      end
    end
  end

  // Called at posedge+1; returns at the following posedge+1.
  task automatic step(input logic v, input logic wen, input logic bnw, input logic [31:0] wd,
                      input logic [31:0] a, input logic y, input logic [31:0] exp);
    logic acc;
    port_flat_i = {v, wen, bnw, wd, y};
    addr        = a;
    acc         = v & (~m_pend | y);
    if (acc) exp_q.push_back(wen ? m_rd : exp);
    #1;
    check("out_yumi", {31'd0, port_flat_o[32]}, {31'd0, acc});
    @(posedge clk);
    #1;
    m_pend = acc | (m_pend & ~y);
    if (acc && !wen) m_rd = exp;
    check("out_valid", {31'd0, port_flat_o[33]}, {31'd0, m_pend});
    check("read_data", port_flat_o[31:0], m_rd);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    step(1'b1, 1'b1, 1'b0, d, a, 1'b1, 32'd0);
  endtask

  task automatic wrb(input logic [31:0] a, input logic [7:0] d);
    step(1'b1, 1'b1, 1'b1, {24'd0, d}, a, 1'b1, 32'd0);
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp);
    step(1'b1, 1'b0, 1'b0, 32'd0, a, 1'b1, exp);
  endtask

  task automatic rdb(input logic [31:0] a, input logic [31:0] exp);
    step(1'b1, 1'b0, 1'b1, 32'd0, a, 1'b1, exp);
  endtask

  task automatic idle(input logic y);
    step(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, y, 32'd0);
  endtask

  initial begin
    reset       = 1'b1;
    port_flat_i = '0;
    addr        = '0;
    m_pend      = 1'b0;
    m_rd        = '0;

    #2;
    check("reset_valid", {31'd0, port_flat_o[33]}, 32'd0);
    check("reset_read_data", port_flat_o[31:0], 32'd0);
    check("reset_yumi_idle", {31'd0, port_flat_o[32]}, 32'd0);
    port_flat_i = {1'b1, 35'd0};
    #1;
    check("reset_yumi_comb", {31'd0, port_flat_o[32]}, 32'd1);
    port_flat_i = '0;
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Preload then read back every word.
    for (int i = 0; i < 1024; i++) wr(32'(i) * 32'd4, 32'(i) * 32'h0101_0101);
    for (int i = 0; i < 1024; i++) rd(32'(i) * 32'd4, 32'(i) * 32'h0101_0101);
    idle(1'b1);

    // Byte lanes.
    wr(32'h10, 32'h1122_3344);
    wrb(32'h12, 8'hAA);
    rd(32'h10, 32'h11AA_3344);
    rdb(32'h13, 32'h0000_0011);
    rdb(32'h10, 32'h0000_0044);
    idle(1'b1);

    // Out-of-range: write dropped (aliased word 0x3AB untouched), read returns zero.
    wr(32'hDEAD_DEAD, 32'h1234_5678);
    rd(32'h0000_0EAC, 32'd939 * 32'h0101_0101);
    rd(32'h600D_BEEF, 32'h0000_0000);
    idle(1'b1);

    // Handshake stall.
    wr(32'h0, 32'hCAFE_F00D);
    rd(32'h0, 32'hCAFE_F00D);
    step(1'b1, 1'b0, 1'b0, 32'd0, 32'h4, 1'b0, 32'h0101_0101);
    step(1'b1, 1'b0, 1'b0, 32'd0, 32'h4, 1'b0, 32'h0101_0101);
    step(1'b1, 1'b0, 1'b0, 32'd0, 32'h4, 1'b1, 32'h0101_0101);
    idle(1'b1);

    // Reset mid-operation with a response in flight.
    rd(32'h10, 32'h11AA_3344);
    reset       = 1'b1;
    port_flat_i = '0;
    #1;
    check("midreset_valid", {31'd0, port_flat_o[33]}, 32'd0);
    check("midreset_read_data", port_flat_o[31:0], 32'd0);
    exp_q.delete();
    m_pend = 1'b0;
    m_rd   = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    rd(32'h10, 32'h11AA_3344);
    rdb(32'h12, 32'h0000_00AA);
    idle(1'b1);

    check("queue_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
